// File: rtl/booth_pp_generator.sv
// Radix-4 Booth partial-product generator.
// Accepts one operand pair, builds one unshifted partial product per cycle,
// then presents all of them in parallel to the Wallace reduction stage and
// holds them until the stage releases them.
module booth_pp_generator #(
    parameter int WIDTH  = 8,
    parameter int PP_W   = 2 * WIDTH,
    parameter int NUM_PP = WIDTH / 2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PP_W-1:0]  _0PP,
    output logic [PP_W-1:0]  _1PP,
    output logic [PP_W-1:0]  _2PP,
    output logic [PP_W-1:0]  _3PP,
    output logic [PP_W-1:0]  _4PP,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(NUM_PP);
    localparam int                BX_W     = WIDTH + 3;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_PP - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PP_W-1:0]   PP_ONE   = PP_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [CNT_W-1:0]   r_count;
    logic [PP_W-1:0]    r_pp [NUM_PP];

    logic               w_accept;
    logic               w_last;
    logic [PP_W-1:0]    w_mx;
    logic [PP_W-1:0]    w_mx2;
    logic [BX_W-1:0]    w_bx;
    logic [2:0]         w_group;
    logic [PP_W-1:0]    w_pp_val;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_count == LAST_CNT);

    // Operand extension and Booth group selection for the current count
    always_comb begin
        w_mx    = r_signed ? {{(PP_W - WIDTH){r_m[WIDTH-1]}}, r_m}
                           : {{(PP_W - WIDTH){1'b0}}, r_m};
        w_mx2   = w_mx << 1;
        // Two extension bits above B, and the implicit b[-1]=0 below it
        w_bx    = {{2{r_signed & r_b[WIDTH-1]}}, r_b, 1'b0};
        w_group = 3'(w_bx >> {r_count, 1'b0});
    end

    // Booth digit times extended multiplicand, modulo 2^PP_W
    always_comb begin
        w_pp_val = '0;
        case (w_group)
            3'b001, 3'b010: w_pp_val = w_mx;
            3'b011:         w_pp_val = w_mx2;
            3'b100:         w_pp_val = ~w_mx2 + PP_ONE;
            3'b101, 3'b110: w_pp_val = ~w_mx + PP_ONE;
            default:        w_pp_val = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_next = GEN;
            GEN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Operand latch, generation counter and partial-product registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_count  <= '0;
            for (int unsigned i = 0; i < NUM_PP; i++) begin
                r_pp[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_m      <= multiplicand;
                        r_b      <= multiplier;
                        r_signed <= signed_mode;
                        r_count  <= '0;
                        for (int unsigned i = 0; i < NUM_PP; i++) begin
                            r_pp[i] <= '0;
                        end
                    end
                end
                GEN: begin
                    for (int unsigned i = 0; i < NUM_PP; i++) begin
                        if (32'(r_count) == i) begin
                            r_pp[i] <= w_pp_val;
                        end
                    end
                    r_count <= w_last ? '0 : r_count + CNT_ONE;
                end
                default: begin
                    // DONE: partial products hold until the next accept
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);

    assign _0PP = r_pp[0];
    assign _1PP = r_pp[1];
    assign _2PP = r_pp[2];
    assign _3PP = r_pp[3];
    assign _4PP = r_pp[4];

endmodule

// File: tb/tb_booth_pp_generator.sv
// Testbench for booth_pp_generator: directed vector table, backpressure and
// asynchronous-reset sequences, and a randomized regression against a
// digit-arithmetic reference model.
module tb_booth_pp_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        signed_mode = 1'b0;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] pp0, pp1, pp2, pp3, pp4;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    booth_pp_generator #(.WIDTH(8), .PP_W(16), .NUM_PP(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        ._0PP         (pp0),
        ._1PP         (pp1),
        ._2PP         (pp2),
        ._3PP         (pp3),
        ._4PP         (pp4),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sm;
        logic [7:0]  m;
        logic [7:0]  b;
        logic [15:0] pp [5];
        logic [15:0] ws;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dut_pp(input int i);
        case (i)
            0: return pp0;
            1: return pp1;
            2: return pp2;
            3: return pp3;
            default: return pp4;
        endcase
    endfunction

    function automatic logic [15:0] dut_wsum();
        logic [15:0] s;
        s = pp0 + (pp1 << 2) + (pp2 << 4) + (pp3 << 6) + (pp4 << 8);
        return s;
    endfunction

    // Reference: digit_i = -2*b[2i+1] + b[2i] + b[2i-1] on the extended multiplier
    function automatic logic [15:0] model_pp(input bit sm, input logic [7:0] m,
                                             input logic [7:0] b, input int i);
        int bv, mv, d;
        bv = sm ? int'($signed(b)) : int'(b);
        mv = sm ? int'($signed(m)) : int'(m);
        d  = -2 * ((bv >>> (2*i+1)) & 1) + ((bv >>> (2*i)) & 1)
             + ((i == 0) ? 0 : ((bv >>> (2*i-1)) & 1));
        return 16'(d * mv);
    endfunction

    function automatic logic [15:0] model_prod(input bit sm, input logic [7:0] m,
                                               input logic [7:0] b);
        int p;
        p = sm ? int'($signed(m)) * int'($signed(b)) : int'(m) * int'(b);
        return 16'(p);
    endfunction

    // Present an operand pair and complete the handshake; returns #1 after the accept edge
    task automatic start_op(input bit sm, input logic [7:0] m, input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        signed_mode  = sm;
        multiplicand = m;
        multiplier   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_op(v.sm, v.m, v.b);
        wait_done(lat);
        chk("latency", 32'(lat), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pp%0d_m%0h_b%0h", i, v.m, v.b), 32'(dut_pp(i)), 32'(v.pp[i]));
        end
        chk("weighted_sum", 32'(dut_wsum()), 32'(v.ws));
        release_out();
    endtask

    function automatic vec_t mkvec(input bit sm, input logic [7:0] m, input logic [7:0] b,
                                   input logic [15:0] p0, input logic [15:0] p1,
                                   input logic [15:0] p2, input logic [15:0] p3,
                                   input logic [15:0] p4, input logic [15:0] ws);
        vec_t v;
        v.sm = sm; v.m = m; v.b = b;
        v.pp[0] = p0; v.pp[1] = p1; v.pp[2] = p2; v.pp[3] = p3; v.pp[4] = p4;
        v.ws = ws;
        return v;
    endfunction

    initial begin
        int          lat;
        bit          sm;
        logic [7:0]  m, b;

        vecs[0] = mkvec(1'b0, 8'd3,   8'd5,   16'h0003, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h000F);
        vecs[1] = mkvec(1'b1, 8'hFD,  8'h07,  16'h0003, 16'hFFFA, 16'h0000, 16'h0000, 16'h0000, 16'hFFEB);
        vecs[2] = mkvec(1'b0, 8'hFF,  8'hFF,  16'hFF01, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'hFE01);
        vecs[3] = mkvec(1'b1, 8'h80,  8'h80,  16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h4000);

        // Reset state, checked while reset is held
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pp0", 32'(pp0), 32'd0);
        chk("rst_pp4", 32'(pp4), 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k]);
        end

        // Backpressure: hold DONE for 10 cycles while a new request is offered
        start_op(1'b0, 8'hFF, 8'hFF);
        wait_done(lat);
        chk("bp_latency", 32'(lat), 32'd5);
        @(negedge clk);
        in_valid     = 1'b1;
        signed_mode  = 1'b0;
        multiplicand = 8'd3;
        multiplier   = 8'd5;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_pp0", 32'(pp0), 32'h0000FF01);
            chk("bp_pp4", 32'(pp4), 32'h000000FF);
        end
        in_valid = 1'b0;
        release_out();
        chk("bp_retain_pp0", 32'(pp0), 32'h0000FF01);
        chk("bp_retain_pp4", 32'(pp4), 32'h000000FF);
        @(posedge clk);
        #1;
        chk("bp_no_accept_busy", 32'(busy), 32'd0);

        // Asynchronous reset during GEN at count=2
        start_op(1'b0, 8'd3, 8'd5);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_pp0", 32'(pp0), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_pp0", 32'(pp0), 32'd0);
        chk("arst_pp1", 32'(pp1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_vec(vecs[0]);

        // Randomized regression against the reference model
        for (int n = 0; n < 1000; n++) begin
            sm = 1'($urandom_range(0, 1));
            m  = 8'($urandom);
            b  = 8'($urandom);
            start_op(sm, m, b);
            wait_done(lat);
            chk("rnd_latency", 32'(lat), 32'd5);
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("rnd_pp%0d_s%0d_m%0h_b%0h", i, sm, m, b),
                    32'(dut_pp(i)), 32'(model_pp(sm, m, b, i)));
            end
            chk($sformatf("rnd_product_s%0d_m%0h_b%0h", sm, m, b),
                32'(dut_wsum()), 32'(model_prod(sm, m, b)));
            release_out();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
